// File: rtl/noc_pkg.sv
// noc_pkg: op codes, sequencer state encoding and default widths shared by the NoC blocks.
package noc_pkg;
    localparam int ROUTERS_DEF     = 16;
    localparam int ROUTER_BITS_DEF = 4;
    localparam int PORT_BITS_DEF   = 3;
    localparam int OP_SIZE_DEF     = 4;
    localparam int CYCLE_BITS_DEF  = 16;

    localparam int OP_NOP          = 0;
    localparam int OP_INIT         = 1;
    localparam int OP_LOAD_RT      = 2;
    localparam int OP_LOAD_STAGING = 3;
    localparam int OP_PHASE0       = 4;
    localparam int OP_PHASE1       = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RT,
        S_STAGE,
        S_PH0,
        S_PH1,
        S_DONE
    } state_e;
endpackage

// File: rtl/rt_loader.sv
// rt_loader: streams routing-table rows into the routers during the RT state.
//   clk, rst_n  : clock, synchronous active-low reset
//   run_i       : sequencer's next state is RT
//   rd_vld_i    : per-source valid bits of the row read last cycle
//   rd_port_i   : per-source outports of the row read last cycle
//   rd_en_o     : table read strobe, rd_dst_o: row being read
//   last_o      : final RT cycle (counter reached ROUTERS)
//   op_o        : per-router LOAD_RT/NOP, dst_o/port_o: RTDst and RTOutPort fields
module rt_loader
    import noc_pkg::*;
#(
    parameter int ROUTERS     = ROUTERS_DEF,
    parameter int ROUTER_BITS = ROUTER_BITS_DEF,
    parameter int PORT_BITS   = PORT_BITS_DEF,
    parameter int OP_SIZE     = OP_SIZE_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run_i,
    input  logic [ROUTERS-1:0]             rd_vld_i,
    input  logic [ROUTERS*PORT_BITS-1:0]   rd_port_i,
    output logic                           rd_en_o,
    output logic [ROUTER_BITS-1:0]         rd_dst_o,
    output logic                           last_o,
    output logic [ROUTERS*OP_SIZE-1:0]     op_o,
    output logic [ROUTER_BITS-1:0]         dst_o,
    output logic [ROUTERS*PORT_BITS-1:0]   port_o
);
    localparam logic [ROUTER_BITS:0] LAST = (ROUTER_BITS+1)'(ROUTERS);

    logic                   run_q, rd_en_q, ld_q;
    logic [ROUTER_BITS:0]   k_q, k_d, k_m1;
    logic [ROUTER_BITS-1:0] rd_dst_q, dst_q;

    // k counts from 0 on the first RT cycle; k_d is the value for the coming cycle.
    always_comb begin
        k_d  = run_q ? k_q + 1'b1 : '0;
        k_m1 = k_d - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            k_q      <= '0;
            rd_en_q  <= 1'b0;
            rd_dst_q <= '0;
            ld_q     <= 1'b0;
            dst_q    <= '0;
        end else begin
            run_q    <= run_i;
            k_q      <= run_i ? k_d : '0;
            rd_en_q  <= run_i && (k_d < LAST);
            rd_dst_q <= (run_i && (k_d < LAST)) ? k_d[ROUTER_BITS-1:0] : '0;
            ld_q     <= run_i && (k_d != '0);
            dst_q    <= (run_i && (k_d != '0)) ? k_m1[ROUTER_BITS-1:0] : '0;
        end
    end

    // Row k-1 arrives from the table this cycle; ld_q marks that it belongs to us.
    for (genvar i = 0; i < ROUTERS; i++) begin : g_op
        assign op_o[i*OP_SIZE +: OP_SIZE] = (ld_q && rd_vld_i[i]) ? OP_SIZE'(OP_LOAD_RT) : OP_SIZE'(OP_NOP);
    end

    assign rd_en_o  = rd_en_q;
    assign rd_dst_o = rd_dst_q;
    assign last_o   = run_q && (k_q == LAST);
    assign dst_o    = dst_q;
    assign port_o   = ld_q ? rd_port_i : '0;
endmodule

// File: rtl/noc_sequencer.sv
// noc_sequencer: sequences all NoC routers through init, routing-table load and network cycles.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, max_cycle      : begin a run of max_cycle network cycles (IDLE/DONE only)
//   hold                  : stall before the next LoadStaging
//   all_done              : routers done and traffic drained
//   rt_rd_en/rt_rd_dst    : routing-table read request
//   rt_rd_port/rt_rd_vld  : routing-table row, one cycle after the request
//   router_op             : per-router op, rt_dst/rt_port: routing-table fields
//   in_cycle              : current network cycle
//   busy, finished        : run in progress / run complete
module noc_sequencer
    import noc_pkg::*;
#(
    parameter int ROUTERS     = ROUTERS_DEF,
    parameter int ROUTER_BITS = ROUTER_BITS_DEF,
    parameter int PORT_BITS   = PORT_BITS_DEF,
    parameter int OP_SIZE     = OP_SIZE_DEF,
    parameter int CYCLE_BITS  = CYCLE_BITS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [CYCLE_BITS-1:0]          max_cycle,
    input  logic                           hold,
    input  logic                           all_done,
    output logic                           rt_rd_en,
    output logic [ROUTER_BITS-1:0]         rt_rd_dst,
    input  logic [ROUTERS*PORT_BITS-1:0]   rt_rd_port,
    input  logic [ROUTERS-1:0]             rt_rd_vld,
    output logic [ROUTERS*OP_SIZE-1:0]     router_op,
    output logic [ROUTER_BITS-1:0]         rt_dst,
    output logic [ROUTERS*PORT_BITS-1:0]   rt_port,
    output logic [CYCLE_BITS-1:0]          in_cycle,
    output logic                           busy,
    output logic                           finished
);
    state_e                       state_q, state_d;
    logic                         wait_q, wait_d, busy_q, fin_q, rt_last;
    logic [CYCLE_BITS-1:0]        max_q, max_d, cyc_q, cyc_d, cyc_inc;
    logic [OP_SIZE-1:0]           op_q, op_d;
    logic [ROUTERS*OP_SIZE-1:0]   rt_ops;

    rt_loader #(
        .ROUTERS     (ROUTERS),
        .ROUTER_BITS (ROUTER_BITS),
        .PORT_BITS   (PORT_BITS),
        .OP_SIZE     (OP_SIZE)
    ) u_rt_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_d == S_RT),
        .rd_vld_i  (rt_rd_vld),
        .rd_port_i (rt_rd_port),
        .rd_en_o   (rt_rd_en),
        .rd_dst_o  (rt_rd_dst),
        .last_o    (rt_last),
        .op_o      (rt_ops),
        .dst_o     (rt_dst),
        .port_o    (rt_port)
    );

    // Saturating so an all-ones limit ends on its own count instead of wrapping.
    assign cyc_inc = &cyc_q ? cyc_q : cyc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        wait_d  = 1'b0;
        max_d   = max_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    max_d   = max_cycle;
                    cyc_d   = '0;
                end
            end
            S_INIT:  state_d = S_RT;
            S_RT:    state_d = rt_last ? ((max_q == '0) ? S_DONE : S_STAGE) : S_RT;
            // wait_q is the hold stall: stay until hold drops, then issue LoadStaging.
            S_STAGE: begin
                wait_d  = wait_q && hold;
                state_d = wait_q ? S_STAGE : S_PH0;
            end
            S_PH0:   state_d = S_PH1;
            S_PH1: begin
                cyc_d   = cyc_inc;
                state_d = (cyc_inc == max_q || all_done) ? S_DONE : S_STAGE;
                wait_d  = (state_d == S_STAGE) && hold;
            end
            default: state_d = S_IDLE;
        endcase
        op_d = (state_d == S_INIT)              ? OP_SIZE'(OP_INIT)         :
               (state_d == S_STAGE && !wait_d)  ? OP_SIZE'(OP_LOAD_STAGING) :
               (state_d == S_PH0)               ? OP_SIZE'(OP_PHASE0)       :
               (state_d == S_PH1)               ? OP_SIZE'(OP_PHASE1)       : OP_SIZE'(OP_NOP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            max_q   <= '0;
            cyc_q   <= '0;
            op_q    <= OP_SIZE'(OP_NOP);
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            max_q   <= max_d;
            cyc_q   <= cyc_d;
            op_q    <= op_d;
            busy_q  <= state_d != S_IDLE && state_d != S_DONE;
            fin_q   <= state_d == S_DONE;
        end
    end

    // During RT each router gets its own LOAD_RT/NOP; otherwise one op is broadcast.
    assign router_op = (state_q == S_RT) ? rt_ops : {ROUTERS{op_q}};
    assign in_cycle  = cyc_q;
    assign busy      = busy_q;
    assign finished  = fin_q;
endmodule

// File: tb/tb_noc_sequencer.sv
// tb_noc_sequencer: randomized self-checking bench driven by an expected-schedule model.
module tb_noc_sequencer;
    import noc_pkg::*;
    localparam int R  = 4;
    localparam int RB = 2;
    localparam int PB = 3;
    localparam int OS = 4;
    localparam int CB = 4;
    localparam int BW = R*OS + RB + R*PB + 1 + RB + CB + 2;

    // One expected clock: kind 0 = broadcast op, kind 1 = RT clock with counter k.
    // h/a/s: drive for hold/all_done/start (0, 1, or 2 = random, no effect expected).
    typedef struct {
        int kind; int op; int k; int cyc; int busy; int fin; int h; int a; int s;
    } ent_t;

    logic clk = 0, rst_n = 0, start = 0, hold = 0, all_done = 0;
    logic [CB-1:0] max_cycle = '0;
    logic [R*PB-1:0] rt_rd_port = '0;
    logic [R-1:0] rt_rd_vld = '0;
    logic rt_rd_en, busy, finished;
    logic [RB-1:0] rt_rd_dst, rt_dst;
    logic [R*OS-1:0] router_op;
    logic [R*PB-1:0] rt_port;
    logic [CB-1:0] in_cycle;

    int checks = 0, errs = 0;
    int prev_fin = 0, prev_cyc = 0, ls_cnt = 0;
    int hold_len[32];
    logic [R*PB-1:0] port_mem[R];
    logic [R-1:0] vld_mem[R];
    logic [R*OS-1:0] snap_op = '0;
    logic snap_ok = 1'b0;

    always #5 clk = ~clk;

    noc_sequencer #(
        .ROUTERS(R), .ROUTER_BITS(RB), .PORT_BITS(PB), .OP_SIZE(OS), .CYCLE_BITS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_cycle(max_cycle), .hold(hold),
        .all_done(all_done), .rt_rd_en(rt_rd_en), .rt_rd_dst(rt_rd_dst),
        .rt_rd_port(rt_rd_port), .rt_rd_vld(rt_rd_vld), .router_op(router_op),
        .rt_dst(rt_dst), .rt_port(rt_port), .in_cycle(in_cycle), .busy(busy),
        .finished(finished)
    );

    // Routing-table memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (rt_rd_en) begin
            rt_rd_vld  <= vld_mem[rt_rd_dst];
            rt_rd_port <= port_mem[rt_rd_dst];
        end else begin
            rt_rd_vld  <= R'($urandom);
            rt_rd_port <= (R*PB)'($urandom);
        end
    end

    always @(negedge clk) begin
        if (router_op[OS-1:0] == OS'(OP_LOAD_STAGING)) ls_cnt++;
        if (busy && rt_dst == RB'(2) && router_op != '0) begin
            snap_op <= router_op;
            snap_ok <= 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic ent_t mk(int kind, int op, int k, int cyc, int b, int f, int h, int a, int s);
        ent_t e;
        e.kind = kind; e.op = op; e.k = k; e.cyc = cyc; e.busy = b; e.fin = f;
        e.h = h; e.a = a; e.s = s;
        return e;
    endfunction

    function automatic logic drv(int x);
        return (x == 2) ? ($urandom_range(0, 1) == 1) : (x == 1);
    endfunction

    function automatic logic [BW-1:0] got_vec();
        return {router_op, rt_dst, rt_port, rt_rd_en, rt_rd_dst, in_cycle, busy, finished};
    endfunction

    function automatic logic [BW-1:0] exp_of(ent_t e);
        logic [R*OS-1:0] op = '0;
        logic [RB-1:0] dst = '0, rdd = '0;
        logic [R*PB-1:0] prt = '0;
        logic en = 1'b0;
        if (e.kind == 1) begin
            en  = e.k < R;
            rdd = en ? RB'(e.k) : '0;
            if (e.k >= 1) begin
                dst = RB'(e.k - 1);
                prt = port_mem[e.k-1];
                for (int i = 0; i < R; i++)
                    op[i*OS +: OS] = vld_mem[e.k-1][i] ? OS'(OP_LOAD_RT) : OS'(OP_NOP);
            end
        end else begin
            for (int i = 0; i < R; i++) op[i*OS +: OS] = OS'(e.op);
        end
        return {op, dst, prt, en, rdd, CB'(e.cyc), e.busy[0], e.fin[0]};
    endfunction

    function automatic void fill_mem();
        for (int i = 0; i < R; i++) begin
            vld_mem[i]  = R'($urandom);
            port_mem[i] = (R*PB)'($urandom);
        end
    endfunction

    // Builds the clock-by-clock schedule a run must follow, drives it, checks each clock.
    task automatic play(input string tag, input int mx, input int ad_at);
        ent_t q[$];
        logic [BW-1:0] g, x;
        int c;
        bit term;
        q.push_back(mk(0, OP_NOP, 0, prev_cyc, 0, prev_fin, 2, 2, 1));
        q.push_back(mk(0, OP_INIT, 0, 0, 1, 0, 2, 2, 2));
        for (int k = 0; k <= R; k++) q.push_back(mk(1, 0, k, 0, 1, 0, 2, 2, 2));
        if (mx == 0) begin
            q.push_back(mk(0, OP_NOP, 0, 0, 0, 1, 2, 2, 0));
        end else begin
            c = 1;
            forever begin
                term = (c == mx) || (c == ad_at);
                q.push_back(mk(0, OP_LOAD_STAGING, 0, c-1, 1, 0, 2, 2, 2));
                q.push_back(mk(0, OP_PHASE0, 0, c-1, 1, 0, 2, 2, 1));
                q.push_back(mk(0, OP_PHASE1, 0, c-1, 1, 0, term ? 2 : int'(hold_len[c] > 0),
                               (c == ad_at) ? 1 : ((c == mx) ? 2 : 0), 2));
                if (term) begin
                    q.push_back(mk(0, OP_NOP, 0, c, 0, 1, 2, 2, 0));
                    break;
                end
                for (int s = 0; s < hold_len[c]; s++)
                    q.push_back(mk(0, OP_NOP, 0, c, 1, 0, (s < hold_len[c]-1) ? 1 : 0, 2, 2));
                c++;
            end
        end
        foreach (q[j]) begin
            @(posedge clk); #1;
            start     = drv(q[j].s);
            max_cycle = (j == 0) ? CB'(mx) : CB'($urandom);
            hold      = drv(q[j].h);
            all_done  = drv(q[j].a);
            @(negedge clk);
            g = got_vec();
            x = exp_of(q[j]);
            checks++;
            if (g !== x) begin
                errs++;
                $display("FAIL %s clk%0d got=%h exp=%h", tag, j, g, x);
            end
        end
        start = 0; hold = 0; all_done = 0;
        prev_fin = 1;
        prev_cyc = q[q.size()-1].cyc;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (got_vec() !== '0) begin errs++; $display("FAIL reset_state got=%h exp=0", got_vec()); end
        @(posedge clk); #1;
        rst_n = 1; start = 0;
        @(negedge clk);
        checks++;
        if (got_vec() !== '0) begin errs++; $display("FAIL reset_release got=%h exp=0", got_vec()); end
        prev_fin = 0; prev_cyc = 0;
    endtask

    task automatic test_basic();
        fill_mem();
        for (int i = 0; i < R; i++) vld_mem[i] = '1;
        play("basic", 2, 0);
        checks++;
        if (in_cycle !== CB'(2) || finished !== 1'b1) begin
            errs++; $display("FAIL basic_end got cyc=%0d fin=%b exp cyc=2 fin=1", in_cycle, finished);
        end
    endtask

    task automatic test_row_mask();
        fill_mem();
        vld_mem[2] = 4'b0101;
        snap_ok = 1'b0;
        play("rowmask", 1, 0);
        checks++;
        if (!snap_ok || snap_op !== 16'h0202) begin
            errs++; $display("FAIL row_mask got=%h exp=0202", snap_op);
        end
    endtask

    task automatic test_max_zero();
        int ls0;
        fill_mem();
        ls0 = ls_cnt;
        play("maxzero", 0, 0);
        checks++;
        if (ls_cnt !== ls0 || in_cycle !== '0 || finished !== 1'b1) begin
            errs++; $display("FAIL max_zero got ls=%0d cyc=%0d fin=%b exp ls=%0d cyc=0 fin=1",
                             ls_cnt, in_cycle, finished, ls0);
        end
    endtask

    task automatic test_all_done();
        fill_mem();
        play("alldone", 10, 3);
        checks++;
        if (in_cycle !== CB'(3)) begin errs++; $display("FAIL all_done got=%0d exp=3", in_cycle); end
    endtask

    task automatic test_hold();
        fill_mem();
        hold_len[1] = 5;
        play("hold", 3, 0);
        hold_len[1] = 0;
        checks++;
        if (in_cycle !== CB'(3)) begin errs++; $display("FAIL hold_end got=%0d exp=3", in_cycle); end
    endtask

    task automatic test_reset_mid();
        fill_mem();
        @(posedge clk); #1;
        start = 1; max_cycle = CB'(5);
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (rt_rd_en !== 1'b1 || rt_rd_dst !== RB'(2)) begin
            errs++; $display("FAIL mid_rt got en=%b dst=%0d exp en=1 dst=2", rt_rd_en, rt_rd_dst);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (got_vec() !== '0) begin errs++; $display("FAIL mid_reset got=%h exp=0", got_vec()); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (got_vec() !== '0) begin errs++; $display("FAIL mid_after got=%h exp=0", got_vec()); end
        prev_fin = 0; prev_cyc = 0;
    endtask

    task automatic test_saturate();
        fill_mem();
        play("saturate", 15, 0);
        checks++;
        if (in_cycle !== '1) begin errs++; $display("FAIL saturate got=%0d exp=15", in_cycle); end
    endtask

    task automatic test_back_to_back();
        int mx, ad;
        for (int r = 0; r < 8; r++) begin
            fill_mem();
            foreach (hold_len[i]) hold_len[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            mx = $urandom_range(0, 6);
            ad = $urandom_range(0, 8);
            play("random", mx, ad);
        end
        foreach (hold_len[i]) hold_len[i] = 0;
    endtask

    initial begin
        foreach (hold_len[i]) hold_len[i] = 0;
        fill_mem();
        test_reset();
        test_basic();
        test_row_mask();
        test_max_zero();
        test_all_done();
        test_hold();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule
